// File: rtl/branch_resolve_ctrl_if.sv
// Bundle of the request, comparator, resolution, redirect and flush signals
// of branch_resolve_ctrl.
//   slave  : the controller's view (drives br_ready, cmp_*, res_*, redir_valid,
//            redir_pc, flush, taken_cnt)
//   master : the surrounding pipeline/comparator/fetch view
// Handshakes (br_valid/br_ready and redir_valid/redir_ready): a transfer
// happens on a rising clk edge where valid and ready are both high; the
// source holds valid and its payload stable until that edge.
interface branch_resolve_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_funct3;
  logic [31:0]      br_pc;
  logic [31:0]      br_imm;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic             cmp_un;
  logic [31:0]      cmp_rr1;
  logic [31:0]      cmp_rr2;
  logic             cmp_beq;
  logic             cmp_blt;
  logic             res_valid;
  logic             res_taken;
  logic             res_err;
  logic             redir_valid;
  logic             redir_ready;
  logic [31:0]      redir_pc;
  logic             flush;
  logic [CNT_W-1:0] taken_cnt;

  modport slave (
    input  br_valid, br_funct3, br_pc, br_imm, rs1_data, rs2_data,
    input  cmp_beq, cmp_blt, redir_ready,
    output br_ready, cmp_un, cmp_rr1, cmp_rr2,
    output res_valid, res_taken, res_err,
    output redir_valid, redir_pc, flush, taken_cnt
  );

  modport master (
    output br_valid, br_funct3, br_pc, br_imm, rs1_data, rs2_data,
    output cmp_beq, cmp_blt, redir_ready,
    input  br_ready, cmp_un, cmp_rr1, cmp_rr2,
    input  res_valid, res_taken, res_err,
    input  redir_valid, redir_pc, flush, taken_cnt
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller for the RISC-V core. Accepts one conditional
// branch per handshake, feeds the external comparator, resolves taken/not
// taken from funct3, redirects fetch to pc+imm and flushes wrong-path stages.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : branch_resolve_ctrl_if.slave (request, comparator,
//                resolution, redirect, flush, taken counter)
//   dbg_state  : current FSM state (0 IDLE, 1 EVAL, 2 REDIR, 3 FLUSH)
module branch_resolve_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_resolve_ctrl_if.slave   bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    REDIR = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

  state_t           state_q, state_d;
  logic [2:0]       funct3_q;
  logic [31:0]      pc_q, imm_q, rs1_q, rs2_q, target_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       flush_cnt_q;

  logic [31:0]      target;
  logic             cond;
  logic             illegal;
  logic             take;
  logic             err;

  // Operands go to the comparator straight from the capture registers, so
  // its beq/blt answer is settled during EVAL. That comparator loop is the
  // only input-to-output combinational path (into res_taken/res_err).
  assign bus.cmp_rr1 = rs1_q;
  assign bus.cmp_rr2 = rs2_q;
  assign bus.cmp_un  = funct3_q[1];

  assign target = pc_q + imm_q;

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3_q)
      3'b000:         cond = bus.cmp_beq;
      3'b001:         cond = ~bus.cmp_beq;
      3'b100, 3'b110: cond = bus.cmp_blt;
      3'b101, 3'b111: cond = ~bus.cmp_blt;
      default:        illegal = 1'b1;
    endcase
  end

  // A taken branch to a non-word-aligned target is reported as an error
  // and does not redirect or count.
  assign take = cond & (target[1:0] == 2'b00);
  assign err  = illegal | (cond & (target[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.br_valid) state_d = EVAL;
      EVAL:  state_d = take ? REDIR : IDLE;
      REDIR: if (bus.redir_ready) state_d = (FLUSH_LD == 4'd0) ? IDLE : FLUSH;
      FLUSH: if (flush_cnt_q <= 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      funct3_q    <= 3'b000;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.br_valid) begin
            funct3_q <= bus.br_funct3;
            pc_q     <= bus.br_pc;
            imm_q    <= bus.br_imm;
            rs1_q    <= bus.rs1_data;
            rs2_q    <= bus.rs2_data;
          end
        end
        EVAL: begin
          if (take) begin
            target_q <= target;
            if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        REDIR: begin
          if (bus.redir_ready) flush_cnt_q <= FLUSH_LD;
        end
        FLUSH: begin
          if (flush_cnt_q != 4'd0) flush_cnt_q <= flush_cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.br_ready    = (state_q == IDLE);
  assign bus.res_valid   = (state_q == EVAL);
  assign bus.res_taken   = (state_q == EVAL) & take;
  assign bus.res_err     = (state_q == EVAL) & err;
  assign bus.redir_valid = (state_q == REDIR);
  assign bus.redir_pc    = target_q;
  assign bus.flush       = (state_q == FLUSH);
  assign bus.taken_cnt   = cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 16;
  localparam int NVEC         = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.CNT_W(CNT_W)) bus ();
  branch_resolve_ctrl_if #(.CNT_W(2))     bus2 ();
  logic [1:0] dbg_state, dbg_state2;

  branch_resolve_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  branch_resolve_ctrl #(.FLUSH_CYCLES(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .dbg_state(dbg_state2)
  );

  // Behavioural comparator for each instance
  assign bus.cmp_beq  = (bus.cmp_rr1 == bus.cmp_rr2);
  assign bus.cmp_blt  = bus.cmp_un ? (bus.cmp_rr1 < bus.cmp_rr2)
                                   : ($signed(bus.cmp_rr1) < $signed(bus.cmp_rr2));
  assign bus2.cmp_beq = (bus2.cmp_rr1 == bus2.cmp_rr2);
  assign bus2.cmp_blt = bus2.cmp_un ? (bus2.cmp_rr1 < bus2.cmp_rr2)
                                    : ($signed(bus2.cmp_rr1) < $signed(bus2.cmp_rr2));
  assign bus2.redir_ready = 1'b1;

  // Fetch-side ready: 0 = low, 1 = high, 2 = random; changes 1 time unit
  // after the rising edge so it is stable when sampled.
  int   ready_mode = 1;
  logic ready_drv;
  assign bus.redir_ready = ready_drv;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ready_drv = 1'b0;
      1:       ready_drv = 1'b1;
      default: ready_drv = 1'($urandom_range(0, 1));
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard
  logic [1:0]       exp_q[$];    // {taken, err}
  logic [31:0]      redir_q[$];  // expected redirect targets
  logic [CNT_W-1:0] model_cnt = '0;

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && bus.res_valid) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_taken", 32'(bus.res_taken), 32'(e[1]));
        check("res_err", 32'(bus.res_err), 32'(e[0]));
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] t;
    if (rst_n && bus.redir_valid && bus.redir_ready) begin
      if (redir_q.size() == 0) begin
        check("redir_unexpected", 32'd1, 32'd0);
      end else begin
        t = redir_q.pop_front();
        check("redir_pc", bus.redir_pc, t);
      end
    end
  end

  int flush_run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      flush_run = 0;
    end else if (bus.flush) begin
      flush_run++;
    end else if (flush_run != 0) begin
      check("flush_len", 32'(flush_run), 32'(FLUSH_CYCLES));
      flush_run = 0;
    end
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic        taken;
    logic        err;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[NVEC];

  function automatic void ref_model(input logic [2:0] f3, input logic [31:0] pc, imm, a, b,
                                    output logic taken, output logic err,
                                    output logic [31:0] tgt);
    logic cond;
    logic ill;
    tgt  = pc + imm;
    cond = 1'b0;
    ill  = 1'b0;
    case (f3)
      3'b000:  cond = (a == b);
      3'b001:  cond = (a != b);
      3'b100:  cond = ($signed(a) < $signed(b));
      3'b101:  cond = ($signed(a) >= $signed(b));
      3'b110:  cond = (a < b);
      3'b111:  cond = (a >= b);
      default: ill = 1'b1;
    endcase
    taken = cond && (tgt[1:0] == 2'b00);
    err   = ill || (cond && (tgt[1:0] != 2'b00));
  endfunction

  // Called at a falling edge; returns at the falling edge of the EVAL cycle.
  task automatic send(input logic [2:0] f3, input logic [31:0] pc, imm, a, b,
                      input logic t, input logic e, input logic [31:0] tgt);
    int w = 0;
    while (!bus.br_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.br_ready) check("br_ready_timeout", 32'd0, 32'd1);
    bus.br_valid  = 1'b1;
    bus.br_funct3 = f3;
    bus.br_pc     = pc;
    bus.br_imm    = imm;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    exp_q.push_back({t, e});
    if (t) begin
      redir_q.push_back(tgt);
      if (model_cnt != {CNT_W{1'b1}}) model_cnt = model_cnt + 1'b1;
    end
    @(negedge clk);
    bus.br_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.br_ready && w < 100);
    if (!bus.br_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        t, e;
    logic [31:0] tgt, pc, imm, a, b, r;
    logic [2:0]  f3;

    vecs[0]  = '{3'b000, 32'h100,      32'h20,       32'd5,        32'd5,        1'b1, 1'b0, 32'h120};
    vecs[1]  = '{3'b100, 32'h200,      32'hFFFFFFF0, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 32'h1F0};
    vecs[2]  = '{3'b110, 32'h200,      32'hFFFFFFF0, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'h1F0};
    vecs[3]  = '{3'b000, 32'hFFFFFFF0, 32'h20,       32'd7,        32'd7,        1'b1, 1'b0, 32'h10};
    vecs[4]  = '{3'b010, 32'h100,      32'h20,       32'd5,        32'd5,        1'b0, 1'b1, 32'h120};
    vecs[5]  = '{3'b011, 32'h100,      32'h20,       32'd5,        32'd6,        1'b0, 1'b1, 32'h120};
    vecs[6]  = '{3'b000, 32'h100,      32'h2,        32'd8,        32'd8,        1'b0, 1'b1, 32'h102};
    vecs[7]  = '{3'b001, 32'h1000,     32'h8,        32'd1,        32'd2,        1'b1, 1'b0, 32'h1008};
    vecs[8]  = '{3'b001, 32'h1000,     32'h8,        32'd3,        32'd3,        1'b0, 1'b0, 32'h1008};
    vecs[9]  = '{3'b101, 32'h40,       32'h40,       32'd1,        32'hFFFFFFFF, 1'b1, 1'b0, 32'h80};
    vecs[10] = '{3'b111, 32'h40,       32'h40,       32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 32'h80};
    vecs[11] = '{3'b100, 32'h40,       32'h40,       32'd3,        32'd3,        1'b0, 1'b0, 32'h80};
    vecs[12] = '{3'b110, 32'h0,        32'h100,      32'd0,        32'h80000000, 1'b1, 1'b0, 32'h100};
    vecs[13] = '{3'b101, 32'h100,      32'h1,        32'd5,        32'd5,        1'b0, 1'b1, 32'h101};
    vecs[14] = '{3'b000, 32'h100,      32'h2,        32'd1,        32'd2,        1'b0, 1'b0, 32'h102};

    bus.br_valid = 1'b0;  bus.br_funct3 = '0; bus.br_pc = '0; bus.br_imm = '0;
    bus.rs1_data = '0;    bus.rs2_data = '0;
    bus2.br_valid = 1'b0; bus2.br_funct3 = '0; bus2.br_pc = '0; bus2.br_imm = '0;
    bus2.rs1_data = '0;   bus2.rs2_data = '0;

    // Reset values
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_br_ready", 32'(bus.br_ready), 32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_redir_valid", 32'(bus.redir_valid), 32'd0);
    check("rst_redir_pc", bus.redir_pc, 32'd0);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_cmp_un", 32'(bus.cmp_un), 32'd0);
    check("rst_cmp_rr1", bus.cmp_rr1, 32'd0);
    check("rst_cmp_rr2", bus.cmp_rr2, 32'd0);
    check("rst_taken_cnt", 32'(bus.taken_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: beq taken, cycle-by-cycle latency and flush window
    send(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 1'b0, 32'h120);
    check("t1_res_valid_c1", 32'(bus.res_valid), 32'd1);
    check("t1_state_c1", 32'(dbg_state), 32'd1);
    @(negedge clk);
    check("t1_redir_valid_c2", 32'(bus.redir_valid), 32'd1);
    check("t1_redir_pc_c2", bus.redir_pc, 32'h120);
    @(negedge clk);
    check("t1_flush_c3", 32'(bus.flush), 32'd1);
    @(negedge clk);
    check("t1_flush_c4", 32'(bus.flush), 32'd1);
    @(negedge clk);
    check("t1_flush_c5", 32'(bus.flush), 32'd0);
    check("t1_ready_c5", 32'(bus.br_ready), 32'd1);
    check("t1_taken_cnt", 32'(bus.taken_cnt), 32'd1);

    // T2: signed vs unsigned less-than on the same operands
    send(3'b100, 32'h200, 32'h0, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 32'h200);
    check("t2_cmp_un_signed", 32'(bus.cmp_un), 32'd0);
    wait_idle();
    send(3'b110, 32'h200, 32'h0, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'h200);
    check("t2_cmp_un_unsigned", 32'(bus.cmp_un), 32'd1);
    @(negedge clk);
    check("t2_ready_c2", 32'(bus.br_ready), 32'd1);

    // Table vectors (wrap, illegal funct3, misaligned target, all conditions)
    for (int i = 0; i < NVEC; i++) begin
      send(vecs[i].f3, vecs[i].pc, vecs[i].imm, vecs[i].a, vecs[i].b,
           vecs[i].taken, vecs[i].err, vecs[i].tgt);
      wait_idle();
      check("vec_taken_cnt", 32'(bus.taken_cnt), 32'(model_cnt));
    end

    // Random branches with a randomly stalling fetch
    ready_mode = 2;
    for (int i = 0; i < 24; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom();
      b   = ($urandom_range(0, 2) == 0) ? a : $urandom();
      r   = $urandom();
      pc  = r & 32'hFFFFFFFC;
      r   = $urandom();
      imm = {{20{r[11]}}, r[11:1], 1'b0};
      ref_model(f3, pc, imm, a, b, t, e, tgt);
      send(f3, pc, imm, a, b, t, e, tgt);
      wait_idle();
    end
    check("rand_taken_cnt", 32'(bus.taken_cnt), 32'(model_cnt));

    // T4: redirect stalled 5 cycles; br_valid during REDIR/FLUSH ignored
    ready_mode = 0;
    repeat (2) @(negedge clk);
    send(3'b000, 32'h300, 32'h40, 32'd9, 32'd9, 1'b1, 1'b0, 32'h340);
    bus.br_valid  = 1'b1;
    bus.br_funct3 = 3'b001;
    bus.br_pc     = 32'hDEAD0000;
    bus.rs1_data  = 32'd1;
    bus.rs2_data  = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_redir_valid_hold", 32'(bus.redir_valid), 32'd1);
      check("t4_redir_pc_hold", bus.redir_pc, 32'h340);
      check("t4_br_ready_low", 32'(bus.br_ready), 32'd0);
    end
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    check("t4_flush_a", 32'(bus.flush), 32'd1);
    check("t4_state_flush", 32'(dbg_state), 32'd3);
    @(negedge clk);
    check("t4_flush_b", 32'(bus.flush), 32'd1);
    bus.br_valid = 1'b0;
    wait_idle();
    check("t4_taken_cnt", 32'(bus.taken_cnt), 32'(model_cnt));

    // T6: reset during REDIR drops the redirect and clears the count
    ready_mode = 0;
    repeat (2) @(negedge clk);
    send(3'b000, 32'h400, 32'h10, 32'd1, 32'd1, 1'b1, 1'b0, 32'h410);
    @(negedge clk);
    check("t6_in_redir", 32'(bus.redir_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_redir_valid_rst", 32'(bus.redir_valid), 32'd0);
    check("t6_state_rst", 32'(dbg_state), 32'd0);
    check("t6_br_ready_rst", 32'(bus.br_ready), 32'd1);
    check("t6_taken_cnt_rst", 32'(bus.taken_cnt), 32'd0);
    check("t6_redir_pc_rst", bus.redir_pc, 32'd0);
    redir_q.delete();
    model_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 1;
    repeat (2) @(negedge clk);
    check("t6_no_res_after_rst", 32'(exp_q.size()), 32'd0);

    // CNT_W=2 saturation, FLUSH_CYCLES=0 (no flush, straight back to IDLE)
    for (int i = 1; i <= 5; i++) begin
      int w = 0;
      while (!bus2.br_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (!bus2.br_ready) check("sat_ready_timeout", 32'd0, 32'd1);
      bus2.br_valid  = 1'b1;
      bus2.br_funct3 = 3'b000;
      bus2.br_pc     = 32'(i) << 8;
      bus2.br_imm    = 32'h10;
      bus2.rs1_data  = 32'(i);
      bus2.rs2_data  = 32'(i);
      @(negedge clk);
      bus2.br_valid = 1'b0;
      check("sat_res_taken", 32'({bus2.res_valid, bus2.res_taken}), 32'd3);
      @(negedge clk);
      check("sat_redir_valid", 32'(bus2.redir_valid), 32'd1);
      check("sat_redir_pc", bus2.redir_pc, (32'(i) << 8) + 32'h10);
      @(negedge clk);
      check("sat_no_flush", 32'(bus2.flush), 32'd0);
      check("sat_ready_back", 32'(bus2.br_ready), 32'd1);
      check("sat_taken_cnt", 32'(bus2.taken_cnt), (i < 3) ? 32'(i) : 32'd3);
    end

    repeat (4) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("redir_q_empty", 32'(redir_q.size()), 32'd0);
    check("final_taken_cnt", 32'(bus.taken_cnt), 32'(model_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
